// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// register map addresses and the vector address helper.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_MASK       = 2'd0;
    localparam logic [1:0] ADDR_PENDING    = 2'd1;
    localparam logic [1:0] ADDR_IN_SERVICE = 2'd2;
    localparam logic [1:0] ADDR_ID         = 2'd3;

    localparam int ID_W = 3;

    // Handler address for a channel; the sum deliberately wraps at 16 bits.
    function automatic logic [15:0] calc_vector(input logic [15:0]   base,
                                                input logic [ID_W-1:0] id,
                                                input int unsigned   stride);
        logic [31:0] offs;
        offs = 32'(id) * 32'(stride);
        return base + offs[15:0];
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: the lowest-index active request wins.
module irq_priority_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    // Scan from the top down so the lowest active index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-channel edge/level capture, mask, fixed-priority
// arbitration and a request/acknowledge/end-of-interrupt handshake with the CPU.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no interrupt outstanding; arbitrate when gie=1
//   ST_REQUEST | irq_req high, winner id/vector frozen until ack or abort
//   ST_SERVICE | handler running, no nesting; wait for irq_eoi
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [7:0]  EDGE_MASK     = 8'h00,
    parameter logic [15:0] VECTOR_BASE   = 16'h0008,
    parameter int unsigned VECTOR_STRIDE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               gie,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    input  logic [1:0]         reg_addr,
    input  logic               reg_we,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               irq_req,
    output logic [15:0]        irq_vector,
    output logic [NUM_IRQ-1:0] irq_clr
);

    localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_clr_q, irq_clr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [15:0]        vector_q, vector_d;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] w1c_vec;
    logic [NUM_IRQ-1:0] id_onehot;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic               latched_eligible;
    logic               launch;
    logic               take_ack;
    logic               eoi_done;
    logic [7:0]         rd_mux;
    logic               unused_wdata;

    // Upper write-data bits only matter for wider configurations.
    assign unused_wdata = ^reg_wdata;

    assign eligible = pending_q & mask_q;
    assign set_vec  = (EDGE_SEL & irq_in & ~irq_prev_q) | (~EDGE_SEL & irq_in);
    assign w1c_vec  = (reg_we && reg_addr == ADDR_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    // One-hot decode of the latched id, used for clear, in-service and eligibility.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (id_q == ID_W'(i)) id_onehot[i] = 1'b1;
        end
    end

    assign latched_eligible = |(eligible & id_onehot);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; an abort in REQUEST takes precedence over an ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gie && enc_valid) state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (!gie || !latched_eligible) state_d = ST_IDLE;
                else if (irq_ack)               state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (irq_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign launch   = (state_q == ST_IDLE)    && (state_d == ST_REQUEST);
    assign take_ack = (state_q == ST_REQUEST) && (state_d == ST_SERVICE);
    assign eoi_done = (state_q == ST_SERVICE) && (state_d == ST_IDLE);

    // FSM outputs; the vector is only driven while the request is up.
    always_comb begin
        irq_req    = (state_q == ST_REQUEST);
        irq_vector = (state_q == ST_REQUEST) ? vector_q : 16'h0000;
        irq_clr    = irq_clr_q;
    end

    // Register-file and capture next-state; a new set beats any clear in the same cycle.
    always_comb begin
        mask_d = mask_q;
        if (reg_we && reg_addr == ADDR_MASK) mask_d = reg_wdata[NUM_IRQ-1:0];

        pending_d = (pending_q & ~w1c_vec & ~(take_ack ? id_onehot : '0)) | set_vec;

        in_service_d = in_service_q;
        if (take_ack)      in_service_d = id_onehot;
        else if (eoi_done) in_service_d = '0;

        irq_clr_d = take_ack ? id_onehot : '0;
        id_d      = launch ? enc_id : id_q;
        vector_d  = launch ? calc_vector(VECTOR_BASE, enc_id, VECTOR_STRIDE) : vector_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_prev_q   <= '0;
            irq_clr_q    <= '0;
            id_q         <= '0;
            vector_q     <= '0;
        end else begin
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_prev_q   <= irq_in;
            irq_clr_q    <= irq_clr_d;
            id_q         <= id_d;
            vector_q     <= vector_d;
        end
    end

    // Combinational register read mux, unused bits zero.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_MASK:       rd_mux[NUM_IRQ-1:0] = mask_q;
            ADDR_PENDING:    rd_mux[NUM_IRQ-1:0] = pending_q;
            ADDR_IN_SERVICE: rd_mux[NUM_IRQ-1:0] = in_service_q;
            ADDR_ID:         rd_mux = {|in_service_q, 4'b0000, id_q};
            default:         rd_mux = '0;
        endcase
        reg_rdata = rd_mux;
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a behavioural model checked every cycle plus
// directed literal expectations, and a wide-configuration instance for vector wrap.
module tb_irq_controller;

    localparam int          N      = 4;
    localparam logic [7:0]  EM     = 8'h07;   // ch0..2 edge, ch3 level
    localparam int          BASE   = 16'h0008;
    localparam int          STRIDE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] irq_in;
    logic        gie, irq_ack, irq_eoi;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [N-1:0] irq_clr;

    logic [7:0]  irq_in8;
    logic [7:0]  rdata8;
    logic        req8;
    logic [15:0] vec8;
    logic [7:0]  clr8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_IRQ(N), .EDGE_MASK(EM), .VECTOR_BASE(16'h0008), .VECTOR_STRIDE(2)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .gie(gie), .irq_ack(irq_ack),
        .irq_eoi(irq_eoi), .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .irq_req(irq_req), .irq_vector(irq_vector), .irq_clr(irq_clr)
    );

    irq_controller #(
        .NUM_IRQ(8), .EDGE_MASK(8'h00), .VECTOR_BASE(16'hFFF0), .VECTOR_STRIDE(4)
    ) dut8 (
        .clk(clk), .reset(reset), .irq_in(irq_in8), .gie(gie), .irq_ack(irq_ack),
        .irq_eoi(irq_eoi), .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_rdata(rdata8), .irq_req(req8), .irq_vector(vec8), .irq_clr(clr8)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_pend = '0, m_mask = '0, m_prev = '0, m_clr = '0;
    bit           m_req = 0, m_svc = 0;
    int           m_id = 0, m_vec = 0;

    initial forever begin : model
        logic [N-1:0] set_v;
        logic [N-1:0] nclr;
        int           win;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_clr = '0;
            m_req = 0; m_svc = 0; m_id = 0; m_vec = 0;
        end else begin
            for (int c = 0; c < N; c++)
                set_v[c] = EM[c] ? (irq_in[c] && !m_prev[c]) : irq_in[c];
            nclr = '0;
            if (m_req) begin
                if (!gie || !(m_pend[m_id] && m_mask[m_id])) m_req = 0;
                else if (irq_ack) begin
                    m_req = 0; m_svc = 1; nclr[m_id] = 1'b1;
                end
            end else if (m_svc) begin
                if (irq_eoi) m_svc = 0;
            end else if (gie) begin
                win = -1;
                for (int c = N - 1; c >= 0; c--)
                    if (m_pend[c] && m_mask[c]) win = c;
                if (win >= 0) begin
                    m_req = 1; m_id = win; m_vec = (BASE + win * STRIDE) % 65536;
                end
            end
            if (reg_we && reg_addr == 2'd1) m_pend = m_pend & ~reg_wdata[N-1:0];
            m_pend = (m_pend & ~nclr) | set_v;
            if (reg_we && reg_addr == 2'd0) m_mask = reg_wdata[N-1:0];
            m_prev = irq_in;
            m_clr  = nclr;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin : compare
        logic [7:0] exp_rd;
        @(negedge clk);
        case (reg_addr)
            2'd0:    exp_rd = {4'b0000, m_mask};
            2'd1:    exp_rd = {4'b0000, m_pend};
            2'd2:    exp_rd = m_svc ? 8'(1 << m_id) : 8'h00;
            default: exp_rd = {m_svc, 4'b0000, 3'(m_id)};
        endcase
        chk("model_req", 16'(irq_req), 16'(m_req));
        chk("model_vector", irq_vector, m_req ? 16'(m_vec) : 16'h0000);
        chk("model_clr", 16'(irq_clr), 16'(m_clr));
        chk("model_rdata", 16'(reg_rdata), 16'(exp_rd));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        cyc(1);
        reg_we = 1'b0; reg_addr = 2'd1; reg_wdata = 8'h00;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; irq_in = '0; irq_in8 = '0; gie = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        reg_addr = 2'd1; reg_we = 1'b0; reg_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 16'(irq_req), 16'h0);
        chk("rst_vector", irq_vector, 16'h0000);
        chk("rst_pending", 16'(reg_rdata), 16'h00);
        @(posedge clk); #1 reset = 1'b0;

        // single edge on ch2
        gie = 1'b1;
        wr(2'd0, 8'h0F);
        irq_in = 4'b0100; cyc(1); irq_in = '0;
        @(negedge clk);
        chk("edge_pending_n1", 16'(reg_rdata), 16'h04);
        chk("edge_req_n1", 16'(irq_req), 16'h0);
        cyc(1); @(negedge clk);
        chk("edge_req_n2", 16'(irq_req), 16'h1);
        chk("edge_vector", irq_vector, 16'h000C);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0; reg_addr = 2'd3;
        @(negedge clk);
        chk("ack_clr", 16'(irq_clr), 16'h0004);
        chk("ack_id_reg", 16'(reg_rdata), 16'h0082);
        reg_addr = 2'd1;
        cyc(1); @(negedge clk);
        chk("clr_one_cycle", 16'(irq_clr), 16'h0000);
        irq_eoi = 1'b1; cyc(1); irq_eoi = 1'b0; cyc(1);

        // simultaneous ch1 and ch3
        irq_in = 4'b1010; cyc(1); irq_in = '0;
        cyc(1); @(negedge clk);
        chk("prio_vector_ch1", irq_vector, 16'h000A);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        @(negedge clk);
        chk("prio_clr_ch1", 16'(irq_clr), 16'h0002);
        chk("prio_pending_left", 16'(reg_rdata), 16'h08);
        irq_eoi = 1'b1; cyc(1); irq_eoi = 1'b0;
        cyc(1); @(negedge clk);
        chk("prio_vector_ch3", irq_vector, 16'h000E);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        @(negedge clk);
        chk("prio_clr_ch3", 16'(irq_clr), 16'h0008);
        irq_eoi = 1'b1; cyc(1); irq_eoi = 1'b0; cyc(1);

        // gie drop while requesting
        irq_in = 4'b0100; cyc(1); irq_in = '0;
        cyc(1); @(negedge clk);
        chk("gie_req_up", 16'(irq_req), 16'h1);
        gie = 1'b0; cyc(1); @(negedge clk);
        chk("gie_req_down", 16'(irq_req), 16'h0);
        chk("gie_pending_kept", 16'(reg_rdata), 16'h04);
        chk("gie_no_clr", 16'(irq_clr), 16'h0);
        wr(2'd1, 8'h04); @(negedge clk);
        chk("w1c_ch2", 16'(reg_rdata), 16'h00);

        // set beats write-1-to-clear
        irq_in = 4'b0001; cyc(1); irq_in = '0; cyc(1);
        @(negedge clk);
        chk("ch0_pending", 16'(reg_rdata), 16'h01);
        irq_in = 4'b0001; wr(2'd1, 8'h01);
        @(negedge clk);
        chk("set_wins", 16'(reg_rdata), 16'h01);
        wr(2'd1, 8'h01);
        @(negedge clk);
        chk("w1c_ch0", 16'(reg_rdata), 16'h00);
        irq_in = '0;

        // masked channel, then unmask; stray eoi in REQUEST ignored
        wr(2'd0, 8'h0B); gie = 1'b1;
        irq_in = 4'b0100; cyc(1); irq_in = '0; cyc(2);
        @(negedge clk);
        chk("masked_no_req", 16'(irq_req), 16'h0);
        wr(2'd0, 8'h0F); cyc(1);
        irq_eoi = 1'b1; cyc(1); irq_eoi = 1'b0;
        @(negedge clk);
        chk("unmask_req", 16'(irq_req), 16'h1);
        chk("unmask_vector", irq_vector, 16'h000C);

        // reset while in SERVICE
        irq_ack = 1'b1; @(posedge clk); #1 irq_ack = 1'b0; reg_addr = 2'd2;
        #1 chk("svc_in_service", 16'(reg_rdata), 16'h04);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_req", 16'(irq_req), 16'h0);
        chk("rst_async_vec", irq_vector, 16'h0000);
        chk("rst_async_clr", 16'(irq_clr), 16'h0);
        chk("rst_async_insvc", 16'(reg_rdata), 16'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; reg_addr = 2'd1;

        // level ch3 held high: pending survives the ack clear
        wr(2'd0, 8'h08);
        irq_in = 4'b1000; cyc(2);
        @(negedge clk);
        chk("level_req", 16'(irq_req), 16'h1);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        @(negedge clk);
        chk("level_clr", 16'(irq_clr), 16'h0008);
        chk("level_pending", 16'(reg_rdata), 16'h08);
        irq_in = '0; irq_eoi = 1'b1; cyc(1); irq_eoi = 1'b0;
        wr(2'd1, 8'h08); cyc(2);

        // 8-channel instance: vector wraps past 16'hFFFF
        wr(2'd0, 8'hFF);
        irq_in8 = 8'h80; cyc(2);
        @(negedge clk);
        chk("wide_req", 16'(req8), 16'h1);
        chk("wide_vector_wrap", vec8, 16'h000C);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0; reg_addr = 2'd3;
        @(negedge clk);
        chk("wide_clr", 16'(clr8), 16'h0080);
        chk("wide_id_reg", 16'(rdata8), 16'h0087);
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of interrupt channels, legal range 1..8.
REQ-002 Parameter EDGE_MASK, default 8'h00, per-channel mode: bit=1 rising-edge, bit=0 level.
REQ-003 Parameter VECTOR_BASE, default 16'h0008, 16-bit vector address of channel 0.
REQ-004 Parameter VECTOR_STRIDE, default 2, vector spacing in instruction words.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 irq_in  in  NUM_IRQ  interrupt sources, already synchronous to clk.
REQ-008 gie  in  1  CPU global interrupt enable.
REQ-009 irq_ack  in  1  one-cycle CPU pulse: vector consumed, entering handler.
REQ-010 irq_eoi  in  1  one-cycle CPU pulse: return-from-interrupt executed.
REQ-011 reg_addr  in  2  register select: 0=MASK, 1=PENDING, 2=IN_SERVICE, 3=ID.
REQ-012 reg_we  in  1  register write strobe.
REQ-013 reg_wdata  in  8  write data.
REQ-014 reg_rdata  out  8  combinational read data of selected register, unused bits 0.
REQ-015 irq_req  out  1  interrupt request to CPU.
REQ-016 irq_vector  out  16  handler address, valid while irq_req=1.
REQ-017 irq_clr  out  NUM_IRQ  one-hot one-cycle clear pulse to the acknowledged source.

Function
REQ-018 Edge channel: pending bit sets on cycle after irq_in rises (0 in previous sample, 1 now); level channel: pending sets each cycle irq_in=1.
REQ-019 PENDING write: write-1-to-clear; write of 0 bits has no effect.
REQ-020 Same-cycle set and clear of a pending bit: set wins.
REQ-021 MASK write replaces mask bits [NUM_IRQ-1:0]; channel eligible when pending & mask.
REQ-022 Arbitration fixed priority, lowest index highest.
REQ-023 FSM states IDLE, REQUEST, SERVICE.
REQ-024 IDLE -> REQUEST when gie=1 and any eligible channel; winner id and vector = VECTOR_BASE + id*VECTOR_STRIDE (16-bit wrap) latched.
REQ-025 REQUEST: irq_req=1, id and vector frozen; a higher-priority arrival does not preempt.
REQ-026 REQUEST -> IDLE with no clear if gie falls or latched channel becomes ineligible; irq_req low the next cycle.
REQ-027 REQUEST + irq_ack -> SERVICE: clear latched pending bit, pulse irq_clr[id] exactly one cycle, set IN_SERVICE[id].
REQ-028 SERVICE: irq_req=0, no nesting; irq_eoi -> IDLE, IN_SERVICE cleared.
REQ-029 irq_ack outside REQUEST and irq_eoi outside SERVICE ignored.
REQ-030 Latency: eligible edge at cycle N pending N+1, irq_req N+2 (with gie=1, IDLE).
REQ-031 ID register reads {in-service flag bit7, 4'b0, latched id[2:0]}.

Reset
REQ-032 Reset forces IDLE, MASK=0, PENDING=0, IN_SERVICE=0, id=0, edge-sample regs=0.
REQ-033 Under reset irq_req=0, irq_vector=16'h0000, irq_clr=0, reg_rdata reflects zeroed registers.
REQ-034 Reset mid-REQUEST or mid-SERVICE abandons the interrupt with no irq_clr pulse.

Structure
REQ-035 Shared package irq_ctrl_pkg holds state encoding and register address constants.
REQ-036 One sub-module irq_priority_enc: combinational NUM_IRQ-wide priority encoder, outputs valid and id.

Verification
REQ-037 MASK=4'hF, gie=1, edge pulse on irq_in[2] -> irq_req at +2 cycles, irq_vector=16'h000C; ack -> irq_clr=4'b0100 one cycle.
REQ-038 irq_in=4'b1010 same cycle, all enabled -> vector 16'h000A (ch1); after ack/eoi, ch3 served with 16'h000E.
REQ-039 In REQUEST for ch2, drop gie -> irq_req 0 next cycle, PENDING still 4'b0100, no irq_clr.
REQ-040 Write PENDING=8'h01 in same cycle as new edge on ch0 -> PENDING bit0 remains 1.
REQ-041 Assert reset during SERVICE -> all outputs 0 asynchronously, IN_SERVICE reads 8'h00.
REQ-042 NUM_IRQ=8, VECTOR_BASE=16'hFFF0, STRIDE=4, ch7 -> vector 16'h000C (wrap).
